// File: rtl/wvb_reader_pkg.sv
// Shared constants for the mDOM waveform-buffer readout: header/sample field
// layout, packet framing and the reader state encoding.
package wvb_pkg;

  localparam int ADR_W         = 12;
  localparam int HDR_START_LSB = 0;
  localparam int HDR_STOP_LSB  = 12;
  localparam int HDR_LTC_LSB   = 24;
  localparam int HDR_LTC_W     = 48;
  localparam int HDR_TRIG_LSB  = 72;
  localparam int HDR_TRIG_W    = 2;
  localparam int HDR_OVF_BIT   = 74;

  localparam int SMP_ADC_LSB   = 0;
  localparam int SMP_ADC_W     = 12;
  localparam int SMP_DISCR_LSB = 12;
  localparam int SMP_DISCR_W   = 8;
  localparam int SMP_TOT_BIT   = 20;
  localparam int SMP_EOE_BIT   = 21;

  // Framing constants are also hard-coded in the software decoder.
  localparam logic [3:0] PKT_MARKER = 4'h9;
  localparam logic [2:0] HDR_WORDS  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR      = 3'd1,
    S_SEND_HDR = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_SEND_A   = 3'd4,
    S_SEND_B   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  function automatic logic [ADR_W:0] calc_n(input logic [ADR_W-1:0] start_addr,
                                            input logic [ADR_W-1:0] stop_addr);
    logic [ADR_W-1:0] diff;
    diff = stop_addr - start_addr;
    return {1'b0, diff} + {{ADR_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/wvb_reader_if.sv
// Header-FIFO, sample-read and output-stream signals of the waveform reader.
interface wvb_reader_if #(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_HDR_WIDTH  = 160
);
  logic                    hdr_empty;
  logic [P_HDR_WIDTH-1:0]  hdr_data_out;
  logic                    hdr_rdreq;
  logic [P_DATA_WIDTH-1:0] wvb_data_out;
  logic                    wvb_rdreq;
  logic                    wvb_rddone;
  logic [15:0]             dout;
  logic                    dout_valid;
  logic                    dout_ready;

  modport master (
    input  hdr_empty, hdr_data_out, wvb_data_out, dout_ready,
    output hdr_rdreq, wvb_rdreq, wvb_rddone, dout, dout_valid
  );

  modport slave (
    output hdr_empty, hdr_data_out, wvb_data_out, dout_ready,
    input  hdr_rdreq, wvb_rdreq, wvb_rddone, dout, dout_valid
  );
endinterface

// File: rtl/wvb_reader_hdr_unpack.sv
// Combinational header field extraction and waveform length (wrap-aware).
module wvb_hdr_unpack
  import wvb_pkg::*;
#(
  parameter int P_HDR_WIDTH = 160
) (
  input  logic [P_HDR_WIDTH-1:0] hdr,
  output logic [ADR_W-1:0]       start_addr,
  output logic [ADR_W-1:0]       stop_addr,
  output logic [HDR_LTC_W-1:0]   ltc,
  output logic [HDR_TRIG_W-1:0]  trig_src,
  output logic                   overflow,
  output logic [ADR_W:0]         n
);
  logic unused_rsvd_s;

  assign start_addr    = hdr[HDR_START_LSB +: ADR_W];
  assign stop_addr     = hdr[HDR_STOP_LSB +: ADR_W];
  assign ltc           = hdr[HDR_LTC_LSB +: HDR_LTC_W];
  assign trig_src      = hdr[HDR_TRIG_LSB +: HDR_TRIG_W];
  assign overflow      = hdr[HDR_OVF_BIT];
  assign n             = calc_n(start_addr, stop_addr);
  assign unused_rsvd_s = ^hdr[P_HDR_WIDTH-1:HDR_OVF_BIT+1];
endmodule

// File: rtl/wvb_reader.sv
// Waveform-buffer readout: pops one header, reads its samples and serialises
// header plus samples into a 16-bit valid/ready packet stream.
module wvb_reader
  import wvb_pkg::*;
#(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_HDR_WIDTH  = 160,
  parameter int P_LTC_WIDTH  = 48,
  parameter int P_RD_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  wvb_reader_if.master     bus,
  output logic             busy,
  output logic             eoe_err
);
  logic [P_ADR_WIDTH-1:0]  start_s, stop_s;
  logic [P_LTC_WIDTH-1:0]  ltc_s;
  logic [1:0]              trig_s;
  logic                    ovf_s;
  logic [P_ADR_WIDTH:0]    n_s;
  logic [15:0]             hdr_word_s;

  state_t                  state_q, state_d;
  logic [2:0]              word_idx_q, word_idx_d;
  logic [7:0]              wait_q, wait_d;
  logic [P_ADR_WIDTH-1:0]  remain_q, remain_d;
  logic [P_ADR_WIDTH:0]    n_q, n_d;
  logic [P_LTC_WIDTH-1:0]  ltc_q, ltc_d;
  logic [1:0]              trig_q, trig_d;
  logic                    ovf_q, ovf_d;
  logic [P_DATA_WIDTH-1-SMP_DISCR_LSB:0] smp_hi_q, smp_hi_d;
  logic [15:0]             dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    hdr_rdreq_q, hdr_rdreq_d;
  logic                    wvb_rdreq_q, wvb_rdreq_d;
  logic                    wvb_rddone_q, wvb_rddone_d;
  logic                    busy_q, busy_d;
  logic                    eoe_err_q, eoe_err_d;
  logic                    eoe_s;

  wvb_hdr_unpack #(.P_HDR_WIDTH(P_HDR_WIDTH)) u_unpack (
    .hdr        (bus.hdr_data_out),
    .start_addr (start_s),
    .stop_addr  (stop_s),
    .ltc        (ltc_s),
    .trig_src   (trig_s),
    .overflow   (ovf_s),
    .n          (n_s)
  );

  assign eoe_s = bus.wvb_data_out[SMP_EOE_BIT];

  // Header word selected by the current word index.
  always_comb begin
    hdr_word_s = 16'h0000;
    case (word_idx_q)
      3'd0:    hdr_word_s = {PKT_MARKER, 2'b00, trig_q, ovf_q, 7'b0000000};
      3'd1:    hdr_word_s = {{(15-P_ADR_WIDTH){1'b0}}, n_q};
      3'd2:    hdr_word_s = ltc_q[47:32];
      3'd3:    hdr_word_s = ltc_q[31:16];
      3'd4:    hdr_word_s = ltc_q[15:0];
      default: hdr_word_s = 16'h0000;
    endcase
  end

  // Next-state and next-output computation for the packet sequencer.
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    wait_d       = wait_q;
    remain_d     = remain_q;
    n_d          = n_q;
    ltc_d        = ltc_q;
    trig_d       = trig_q;
    ovf_d        = ovf_q;
    smp_hi_d     = smp_hi_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    hdr_rdreq_d  = 1'b0;
    wvb_rdreq_d  = 1'b0;
    wvb_rddone_d = 1'b0;
    eoe_err_d    = eoe_err_q;
    case (state_q)
      S_IDLE: begin
        if (en && !bus.hdr_empty) begin
          state_d     = S_HDR;
          hdr_rdreq_d = 1'b1;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_HDR: begin
        // The FIFO head is still valid during the pop cycle.
        state_d    = S_SEND_HDR;
        n_d        = n_s;
        remain_d   = stop_s - start_s;
        ltc_d      = ltc_s;
        trig_d     = trig_s;
        ovf_d      = ovf_s;
        word_idx_d = 3'd0;
      end
      S_SEND_HDR: begin
        if (!dout_valid_q || bus.dout_ready) begin
          if (word_idx_q < HDR_WORDS) begin
            dout_d       = hdr_word_s;
            dout_valid_d = 1'b1;
            word_idx_d   = word_idx_q + 3'd1;
          end else begin
            dout_valid_d = 1'b0;
            wait_d       = 8'd0;
            state_d      = S_RD_WAIT;
          end
        end else begin
          state_d = S_SEND_HDR;
        end
      end
      S_RD_WAIT: begin
        if (wait_q == 8'(P_RD_LATENCY - 1)) begin
          smp_hi_d     = bus.wvb_data_out[P_DATA_WIDTH-1:SMP_DISCR_LSB];
          dout_d       = {4'b0000, bus.wvb_data_out[SMP_ADC_LSB +: SMP_ADC_W]};
          dout_valid_d = 1'b1;
          state_d      = S_SEND_A;
          // EOE must be set on the last sample only; length still follows n.
          if (eoe_s != (remain_q == {P_ADR_WIDTH{1'b0}})) begin
            eoe_err_d = 1'b1;
          end else begin
            eoe_err_d = eoe_err_q;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_SEND_A: begin
        if (bus.dout_ready) begin
          dout_d  = {6'b000000, smp_hi_q};
          state_d = S_SEND_B;
        end else begin
          state_d = S_SEND_A;
        end
      end
      S_SEND_B: begin
        if (bus.dout_ready) begin
          dout_valid_d = 1'b0;
          if (remain_q != {P_ADR_WIDTH{1'b0}}) begin
            remain_d    = remain_q - {{(P_ADR_WIDTH-1){1'b0}}, 1'b1};
            wvb_rdreq_d = 1'b1;
            wait_d      = 8'd0;
            state_d     = S_RD_WAIT;
          end else begin
            wvb_rddone_d = 1'b1;
            state_d      = S_DONE;
          end
        end else begin
          state_d = S_SEND_B;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any packet in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      word_idx_q   <= 3'd0;
      wait_q       <= 8'd0;
      remain_q     <= {P_ADR_WIDTH{1'b0}};
      n_q          <= {(P_ADR_WIDTH+1){1'b0}};
      ltc_q        <= {P_LTC_WIDTH{1'b0}};
      trig_q       <= 2'b00;
      ovf_q        <= 1'b0;
      smp_hi_q     <= '0;
      dout_q       <= 16'h0000;
      dout_valid_q <= 1'b0;
      hdr_rdreq_q  <= 1'b0;
      wvb_rdreq_q  <= 1'b0;
      wvb_rddone_q <= 1'b0;
      busy_q       <= 1'b0;
      eoe_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      wait_q       <= wait_d;
      remain_q     <= remain_d;
      n_q          <= n_d;
      ltc_q        <= ltc_d;
      trig_q       <= trig_d;
      ovf_q        <= ovf_d;
      smp_hi_q     <= smp_hi_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      hdr_rdreq_q  <= hdr_rdreq_d;
      wvb_rdreq_q  <= wvb_rdreq_d;
      wvb_rddone_q <= wvb_rddone_d;
      busy_q       <= busy_d;
      eoe_err_q    <= eoe_err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.hdr_rdreq  = hdr_rdreq_q;
  assign bus.wvb_rdreq  = wvb_rdreq_q;
  assign bus.wvb_rddone = wvb_rddone_q;
  assign busy           = busy_q;
  assign eoe_err        = eoe_err_q;
endmodule

// File: tb/tb_wvb_reader.sv
// Directed bench for wvb_reader: header FIFO and sample buffer models feed the
// reader, a monitor collects the stream and strobes for comparison.
module tb_wvb_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic busy, eoe_err;
  logic rand_mode = 1'b0;

  wvb_reader_if #(.P_DATA_WIDTH(22), .P_HDR_WIDTH(160)) bus ();

  wvb_reader #(
    .P_DATA_WIDTH(22), .P_ADR_WIDTH(12), .P_HDR_WIDTH(160),
    .P_LTC_WIDTH(48), .P_RD_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus.master), .busy(busy), .eoe_err(eoe_err)
  );

  always #5 clk = ~clk;

  // Header FIFO (show-ahead) and sample buffer with address controller.
  logic [159:0] fifo [8];
  logic [2:0]   wr_ptr = 3'd0;
  logic [2:0]   rd_ptr = 3'd0;
  logic [21:0]  mem [4096];
  logic [11:0]  adr = 12'd0;

  assign bus.hdr_empty    = (rd_ptr == wr_ptr);
  assign bus.hdr_data_out = fifo[rd_ptr];
  assign bus.wvb_data_out = mem[adr];

  always @(posedge clk) begin
    if (bus.hdr_rdreq) begin
      rd_ptr <= rd_ptr + 3'd1;
      adr    <= bus.hdr_data_out[11:0];
    end else if (bus.wvb_rdreq) begin
      adr    <= adr + 12'd1;
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0, hdr_cnt = 0, rd_cnt = 0, done_cnt = 0, overlap = 0, stall_err = 0;
  int done_cyc = -1;
  logic [15:0] rx [$];
  int          rx_cyc [$];
  int          gaps [$];
  logic [15:0] exp_q [$];
  logic        stalled_prev = 1'b0;
  logic [15:0] prev_dout = 16'h0000;

  always @(posedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
      done_cyc     = -1;
    end else begin
      if (bus.dout_valid && bus.dout_ready) begin
        rx.push_back(bus.dout);
        rx_cyc.push_back(cyc);
      end
      if (stalled_prev && (!bus.dout_valid || bus.dout !== prev_dout)) stall_err++;
      stalled_prev = bus.dout_valid && !bus.dout_ready;
      prev_dout    = bus.dout;
      if (bus.hdr_rdreq) begin
        hdr_cnt++;
        if (done_cyc >= 0) gaps.push_back(cyc - done_cyc);
      end
      if (bus.wvb_rdreq) rd_cnt++;
      if (bus.wvb_rddone) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (32'(bus.hdr_rdreq) + 32'(bus.wvb_rdreq) + 32'(bus.wvb_rddone) > 32'd1) overlap++;
    end
    cyc++;
  end

  initial begin
    bus.dout_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rand_mode) bus.dout_ready = 1'($urandom_range(0, 1));
      else           bus.dout_ready = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [159:0] mk_hdr(input logic [11:0] start, input logic [11:0] stop,
                                          input logic [47:0] ltc, input logic [1:0] trig,
                                          input logic ovf);
    logic [84:0] rsv;
    rsv = {85{1'b1}};
    return {rsv, ovf, trig, ltc, stop, start};
  endfunction

  task automatic push_hdr(input logic [159:0] h);
    @(negedge clk);
    fifo[wr_ptr] = h;
    wr_ptr = wr_ptr + 3'd1;
  endtask

  task automatic fill_mem(input logic [11:0] start, input int n, input int bad);
    logic [11:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 12'(i);
      mem[a] = {((i == n - 1) || (i == bad)), a[0], a[7:0] ^ 8'hA5, a ^ 12'h5C3};
    end
  endtask

  task automatic build_exp(input logic [11:0] start, input logic [11:0] stop,
                           input logic [47:0] ltc, input logic [1:0] trig, input logic ovf);
    logic [11:0] diff;
    logic [11:0] a;
    logic [21:0] s;
    int n;
    diff = stop - start;
    n = int'(diff) + 1;
    exp_q.push_back({4'h9, 2'b00, trig, ovf, 7'b0000000});
    exp_q.push_back(16'(n));
    exp_q.push_back(ltc[47:32]);
    exp_q.push_back(ltc[31:16]);
    exp_q.push_back(ltc[15:0]);
    for (int i = 0; i < n; i++) begin
      a = start + 12'(i);
      s = mem[a];
      exp_q.push_back({4'h0, s[11:0]});
      exp_q.push_back({6'b000000, s[21], s[20], s[19:12]});
    end
  endtask

  task automatic clear_rx();
    rx.delete();
    rx_cyc.delete();
    exp_q.delete();
  endtask

  task automatic cmp_stream(input string tag);
    int mism;
    int lim;
    mism = 0;
    lim = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
    chk(32'(rx.size()), 32'(exp_q.size()), {tag, "_len"});
    for (int i = 0; i < lim; i++) if (rx[i] !== exp_q[i]) mism++;
    chk(32'(mism), 32'd0, {tag, "_words"});
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(32'(done_cnt >= target), 32'd1, tag);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk(32'(bus.dout), 32'd0, {tag, "_dout"});
    chk(32'(bus.dout_valid), 32'd0, {tag, "_dout_valid"});
    chk(32'(bus.hdr_rdreq), 32'd0, {tag, "_hdr_rdreq"});
    chk(32'(bus.wvb_rdreq), 32'd0, {tag, "_wvb_rdreq"});
    chk(32'(bus.wvb_rddone), 32'd0, {tag, "_wvb_rddone"});
    chk(32'(busy), 32'd0, {tag, "_busy"});
    chk(32'(eoe_err), 32'd0, {tag, "_eoe_err"});
  endtask

  logic [15:0] exp1 [13] = '{16'h9200, 16'h0004, 16'h0123, 16'h4567, 16'h89AB,
                             16'h0123, 16'h0045, 16'h0ABC, 16'h01FF,
                             16'h0000, 16'h0000, 16'h0FFF, 16'h0380};
  logic [159:0] h1;
  int b_hdr, b_rd, b_done;
  int k;
  logic found;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 22'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // Single waveform with hand-computed words.
    mem[12'h010] = {1'b0, 1'b0, 8'h45, 12'h123};
    mem[12'h011] = {1'b0, 1'b1, 8'hFF, 12'hABC};
    mem[12'h012] = {1'b0, 1'b0, 8'h00, 12'h000};
    mem[12'h013] = {1'b1, 1'b1, 8'h80, 12'hFFF};
    h1 = mk_hdr(12'h010, 12'h013, 48'h0123_4567_89AB, 2'd2, 1'b0);
    clear_rx();
    b_hdr = hdr_cnt; b_rd = rd_cnt; b_done = done_cnt;
    push_hdr(h1);
    @(posedge clk); #1;
    chk(32'(bus.hdr_rdreq), 32'd1, "t1_hdr_rdreq_pulse");
    chk(32'(busy), 32'd1, "t1_busy");
    @(posedge clk); #1;
    chk(32'(bus.hdr_rdreq), 32'd0, "t1_hdr_rdreq_one_cycle");
    chk(32'(bus.dout_valid), 32'd0, "t1_w0_not_early");
    @(posedge clk); #1;
    chk(32'(bus.dout_valid), 32'd1, "t1_w0_valid");
    chk(32'(bus.dout), 32'h9200, "t1_w0_value");
    wait_done(b_done + 1, 200, "t1_done");
    chk(32'(rx.size()), 32'd13, "t1_len");
    for (int i = 0; i < 13; i++) chk(32'(rx[i]), 32'(exp1[i]), $sformatf("t1_word%0d", i));
    chk(32'(hdr_cnt - b_hdr), 32'd1, "t1_hdr_rdreq_count");
    chk(32'(rd_cnt - b_rd), 32'd3, "t1_wvb_rdreq_count");
    chk(32'(done_cnt - b_done), 32'd1, "t1_rddone_count");
    chk(32'(rx_cyc[7] - rx_cyc[5]), 32'd4, "t1_sample_period");
    chk(32'(done_cyc - rx_cyc[12]), 32'd1, "t1_rddone_timing");
    chk(32'(eoe_err), 32'd0, "t1_eoe_err");

    // Same packet under random backpressure.
    clear_rx();
    b_done = done_cnt;
    rand_mode = 1'b1;
    push_hdr(h1);
    wait_done(b_done + 1, 400, "t2_done");
    rand_mode = 1'b0;
    chk(32'(rx.size()), 32'd13, "t2_len");
    k = 0;
    for (int i = 0; i < 13; i++) if (rx[i] !== exp1[i]) k++;
    chk(32'(k), 32'd0, "t2_words");
    chk(32'(stall_err), 32'd0, "t2_dout_stable");

    // Address wrap-around.
    fill_mem(12'hFFE, 4, -1);
    clear_rx();
    b_done = done_cnt;
    build_exp(12'hFFE, 12'h001, 48'hFEDC_BA98_7654, 2'd1, 1'b1);
    push_hdr(mk_hdr(12'hFFE, 12'h001, 48'hFEDC_BA98_7654, 2'd1, 1'b1));
    wait_done(b_done + 1, 200, "t3_done");
    cmp_stream("t3");
    chk(32'(rx[0]), 32'h9180, "t3_w0");
    chk(32'(rx[1]), 32'h0004, "t3_w1");
    chk(32'(rx.size() - 5), 32'd8, "t3_sample_words");

    // Full-length waveform.
    fill_mem(12'h000, 4096, -1);
    clear_rx();
    b_rd = rd_cnt; b_done = done_cnt;
    build_exp(12'h000, 12'hFFF, 48'hA5A5_5A5A_0F0F, 2'd3, 1'b0);
    push_hdr(mk_hdr(12'h000, 12'hFFF, 48'hA5A5_5A5A_0F0F, 2'd3, 1'b0));
    wait_done(b_done + 1, 20000, "t4_done");
    cmp_stream("t4");
    chk(32'(rx[1]), 32'h1000, "t4_w1");
    chk(32'(rx.size()), 32'd8197, "t4_len");
    chk(32'(rd_cnt - b_rd), 32'd4095, "t4_wvb_rdreq_count");
    chk(32'(eoe_err), 32'd0, "t4_eoe_err");

    // EOE set on sample 2 of 4.
    fill_mem(12'h020, 4, 1);
    clear_rx();
    b_done = done_cnt;
    build_exp(12'h020, 12'h023, 48'h0000_1111_2222, 2'd0, 1'b0);
    push_hdr(mk_hdr(12'h020, 12'h023, 48'h0000_1111_2222, 2'd0, 1'b0));
    wait_done(b_done + 1, 200, "t5_done");
    cmp_stream("t5");
    chk(32'(eoe_err), 32'd1, "t5_eoe_err_set");
    repeat (5) @(posedge clk);
    #1;
    chk(32'(eoe_err), 32'd1, "t5_eoe_err_sticky");

    // Reset during SEND_A with three headers queued.
    fill_mem(12'h100, 4, -1);
    fill_mem(12'h200, 2, -1);
    fill_mem(12'h300, 3, -1);
    clear_rx();
    push_hdr(mk_hdr(12'h100, 12'h103, 48'h1111_2222_3333, 2'd1, 1'b0));
    push_hdr(mk_hdr(12'h200, 12'h201, 48'h4444_5555_6666, 2'd2, 1'b1));
    push_hdr(mk_hdr(12'h300, 12'h302, 48'h7777_8888_9999, 2'd3, 1'b0));
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (rx.size() == 5 && bus.dout_valid) found = 1'b1;
    end
    chk(32'(found), 32'd1, "t6_reach_send_a");
    rst = 1'b1;
    b_done = done_cnt;
    @(posedge clk); #1;
    chk_zero("t6_reset");
    @(negedge clk);
    rst = 1'b0;
    clear_rx();
    gaps.delete();
    b_hdr = hdr_cnt;
    build_exp(12'h200, 12'h201, 48'h4444_5555_6666, 2'd2, 1'b1);
    build_exp(12'h300, 12'h302, 48'h7777_8888_9999, 2'd3, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (hdr_cnt >= b_hdr + 2) found = 1'b1;
    end
    chk(32'(found), 32'd1, "t6_second_start");
    en = 1'b0;
    wait_done(b_done + 2, 300, "t6_done");
    chk(32'(done_cnt - b_done), 32'd2, "t6_no_abort_rddone");
    cmp_stream("t6");
    chk(32'(gaps.size()), 32'd1, "t6_gap_count");
    chk(32'(gaps[0]), 32'd2, "t6_idle_gap");
    push_hdr(mk_hdr(12'h100, 12'h101, 48'h0, 2'd0, 1'b0));
    repeat (30) @(posedge clk);
    #1;
    chk(32'(hdr_cnt - b_hdr), 32'd2, "t6_en_low_no_start");
    chk(32'(busy), 32'd0, "t6_en_low_idle");
    chk(32'(bus.hdr_empty), 32'd0, "t6_hdr_pending");
    chk(32'(overlap), 32'd0, "strobe_overlap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
